// File: rtl/hram_cmd_ctrl.sv
// HyperRAM command front-end: accepts user read/write requests, builds the
// 48-bit command-address word, packs write bursts and launches one sequencer.
module hram_cmd_ctrl #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  output logic [31:0]  rsp_data,
  output logic         rsp_valid,
  output logic         rsp_last,
  output logic         cmd_done,
  output logic         cmd_err,
  output logic [47:0]  casig,
  output logic [255:0] databuffer,
  output logic         databuffer_valid,
  output logic         rdmem_start,
  output logic         wrmem_start,
  output logic         rdreg_start,
  input  logic         rdmem_end,
  input  logic         wrmem_end,
  input  logic         rdreg_end,
  input  logic [31:0]  rdmem_data,
  input  logic         rdmem_wordvalid,
  input  logic [15:0]  rdreg_data,
  input  logic         rdreg_valid
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TmoMax = TW'(TIMEOUT - 1);

  localparam logic [1:0] OpRdmem = 2'b00;
  localparam logic [1:0] OpWrmem = 2'b01;
  localparam logic [1:0] OpRdreg = 2'b10;

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWait, StDone} state_e;

  state_e        state_q;
  logic [1:0]    op_q;
  logic [2:0]    beat_cnt_q;
  logic [3:0]    word_cnt_q;
  logic [TW-1:0] tmo_cnt_q;

  logic          req_hs;
  logic          wr_hs;
  logic          end_hit;
  logic          word_strobe;
  logic [3:0]    word_cnt_d;
  logic [47:0]   casig_d;
  logic [7:0]    beat_lsb;

  // Handshakes, end selection and command word assembly
  always_comb begin
    req_hs      = req_valid & req_ready;
    wr_hs       = wr_valid & wr_ready;
    end_hit     = ((op_q == OpRdmem) & rdmem_end) |
                  ((op_q == OpWrmem) & wrmem_end) |
                  ((op_q == OpRdreg) & rdreg_end);
    word_strobe = (op_q == OpRdmem) & rdmem_wordvalid;
    // Word counter saturates so an over-long burst still reads as "not 8"
    word_cnt_d  = word_cnt_q;
    if (word_strobe && (word_cnt_q != 4'hf)) begin
      word_cnt_d = word_cnt_q + 4'd1;
    end
    casig_d     = {(req_op == OpRdmem) | (req_op == OpRdreg), (req_op == OpRdreg), 1'b1,
                   req_addr[31:3], 13'd0, req_addr[2:0]};
    // Beat k lands in databuffer[255-32k -: 32], i.e. LSB index (7-k)*32
    beat_lsb    = {3'd7 - beat_cnt_q, 5'd0};
  end

  // Command FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      op_q             <= 2'b00;
      beat_cnt_q       <= 3'd0;
      word_cnt_q       <= 4'd0;
      tmo_cnt_q        <= '0;
      req_ready        <= 1'b0;
      wr_ready         <= 1'b0;
      rsp_data         <= 32'd0;
      rsp_valid        <= 1'b0;
      rsp_last         <= 1'b0;
      cmd_done         <= 1'b0;
      cmd_err          <= 1'b0;
      casig            <= 48'd0;
      databuffer       <= 256'd0;
      databuffer_valid <= 1'b0;
      rdmem_start      <= 1'b0;
      wrmem_start      <= 1'b0;
      rdreg_start      <= 1'b0;
    end else begin
      // Pulse outputs default low
      rdmem_start <= 1'b0;
      wrmem_start <= 1'b0;
      rdreg_start <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_last    <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_err     <= 1'b0;

      unique case (state_q)
        StIdle: begin
          req_ready <= 1'b1;
          if (req_hs) begin
            op_q       <= req_op;
            casig      <= casig_d;
            req_ready  <= 1'b0;
            beat_cnt_q <= 3'd0;
            word_cnt_q <= 4'd0;
            tmo_cnt_q  <= '0;
            unique case (req_op)
              OpWrmem: begin
                state_q  <= StLoad;
                wr_ready <= 1'b1;
              end
              OpRdmem: begin
                state_q     <= StIssue;
                rdmem_start <= 1'b1;
              end
              OpRdreg: begin
                state_q     <= StIssue;
                rdreg_start <= 1'b1;
              end
              default: begin
                state_q  <= StDone;
                cmd_done <= 1'b1;
                cmd_err  <= 1'b1;
              end
            endcase
          end
        end

        StLoad: begin
          if (wr_hs) begin
            databuffer[beat_lsb +: 32] <= wr_data;
            beat_cnt_q                 <= beat_cnt_q + 3'd1;
            if (beat_cnt_q == 3'd7) begin
              wr_ready         <= 1'b0;
              databuffer_valid <= 1'b1;
              wrmem_start      <= 1'b1;
              state_q          <= StIssue;
            end
          end
        end

        StIssue: begin
          databuffer_valid <= 1'b0;
          state_q          <= StWait;
        end

        StWait: begin
          if (word_strobe) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= rdmem_data;
            rsp_last   <= (word_cnt_q == 4'd7);
            word_cnt_q <= word_cnt_d;
          end
          if ((op_q == OpRdreg) && rdreg_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= {16'h0000, rdreg_data};
            rsp_last  <= 1'b1;
          end
          // A matching end wins over a coincident timeout
          if (end_hit) begin
            state_q  <= StDone;
            cmd_done <= 1'b1;
            cmd_err  <= (op_q == OpRdmem) && (word_cnt_d != 4'd8);
          end else if (tmo_cnt_q == TmoMax) begin
            state_q  <= StDone;
            cmd_done <= 1'b1;
            cmd_err  <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        StDone: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hram_cmd_ctrl.sv
// Directed bench for hram_cmd_ctrl (built with TIMEOUT=16).
module tb_hram_cmd_ctrl;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [31:0]  req_addr;
  logic [31:0]  wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic [31:0]  rsp_data;
  logic         rsp_valid;
  logic         rsp_last;
  logic         cmd_done;
  logic         cmd_err;
  logic [47:0]  casig;
  logic [255:0] databuffer;
  logic         databuffer_valid;
  logic         rdmem_start;
  logic         wrmem_start;
  logic         rdreg_start;
  logic         rdmem_end;
  logic         wrmem_end;
  logic         rdreg_end;
  logic [31:0]  rdmem_data;
  logic         rdmem_wordvalid;
  logic [15:0]  rdreg_data;
  logic         rdreg_valid;

  int passed;
  int total;

  hram_cmd_ctrl #(.TIMEOUT(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_addr         (req_addr),
    .wr_data          (wr_data),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .rsp_data         (rsp_data),
    .rsp_valid        (rsp_valid),
    .rsp_last         (rsp_last),
    .cmd_done         (cmd_done),
    .cmd_err          (cmd_err),
    .casig            (casig),
    .databuffer       (databuffer),
    .databuffer_valid (databuffer_valid),
    .rdmem_start      (rdmem_start),
    .wrmem_start      (wrmem_start),
    .rdreg_start      (rdreg_start),
    .rdmem_end        (rdmem_end),
    .wrmem_end        (wrmem_end),
    .rdreg_end        (rdreg_end),
    .rdmem_data       (rdmem_data),
    .rdmem_wordvalid  (rdmem_wordvalid),
    .rdreg_data       (rdreg_data),
    .rdreg_valid      (rdreg_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic request(input logic [1:0] op, input logic [31:0] addr);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
  endtask

  logic [255:0] exp_buf;

  initial begin
    passed = 0;
    total  = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 2'b00; req_addr = 32'd0;
    wr_data = 32'd0; wr_valid = 1'b0;
    rdmem_end = 1'b0; wrmem_end = 1'b0; rdreg_end = 1'b0;
    rdmem_data = 32'd0; rdmem_wordvalid = 1'b0;
    rdreg_data = 16'd0; rdreg_valid = 1'b0;

    // Reset state
    repeat (3) step();
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_cmd_done", cmd_done, 1'b0);
    chkw("rst_casig", 256'(casig), 256'(0));
    chkw("rst_databuffer", databuffer, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    chk1("idle_req_ready", req_ready, 1'b1);
    chk1("idle_wr_ready", wr_ready, 1'b0);

    // rdmem: 8 words, stray wrmem_end mid-burst, rdmem_end with the 8th word
    request(2'b00, 32'h0000_1234);
    chk1("rdmem_start", rdmem_start, 1'b1);
    chk1("rdmem_other_start", wrmem_start | rdreg_start, 1'b0);
    chkw("rdmem_casig", 256'(casig), 256'(48'hA000_0246_0004));
    chk1("rdmem_req_ready_low", req_ready, 1'b0);
    step();
    chk1("rdmem_start_once", rdmem_start, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rdmem_wordvalid = 1'b1;
      rdmem_data      = 32'h1111_1111 * (i + 1);
      wrmem_end       = (i == 2);
      rdmem_end       = (i == 7);
      step();
      chk1("rdmem_rsp_valid", rsp_valid, 1'b1);
      chkw("rdmem_rsp_data", 256'(rsp_data), 256'(32'h1111_1111 * (i + 1)));
      chk1("rdmem_rsp_last", rsp_last, (i == 7));
      chk1("rdmem_cmd_done", cmd_done, (i == 7));
    end
    rdmem_wordvalid = 1'b0;
    rdmem_end       = 1'b0;
    wrmem_end       = 1'b0;
    chk1("rdmem_cmd_err", cmd_err, 1'b0);
    step();
    chk1("rdmem_rsp_valid_off", rsp_valid, 1'b0);
    chk1("rdmem_req_ready_back", req_ready, 1'b1);

    // wrmem: 8 beats 0xA0..0xA7
    request(2'b01, 32'h0000_0010);
    chkw("wrmem_casig", 256'(casig), 256'(48'h2000_0002_0000));
    chk1("wrmem_wr_ready", wr_ready, 1'b1);
    chk1("wrmem_no_early_start", wrmem_start, 1'b0);
    exp_buf = '0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hA0 + i;
      exp_buf[255 - 32 * i -: 32] = 32'hA0 + i;
      step();
    end
    wr_valid = 1'b0;
    chk1("wrmem_start", wrmem_start, 1'b1);
    chk1("wrmem_dbuf_valid", databuffer_valid, 1'b1);
    chk1("wrmem_wr_ready_off", wr_ready, 1'b0);
    chkw("wrmem_dbuf_top", 256'(databuffer[255:224]), 256'(32'hA0));
    chkw("wrmem_dbuf_bot", 256'(databuffer[31:0]), 256'(32'hA7));
    chkw("wrmem_dbuf_all", databuffer, exp_buf);
    step();
    chk1("wrmem_dbuf_valid_clr", databuffer_valid, 1'b0);
    chk1("wrmem_start_once", wrmem_start, 1'b0);
    repeat (2) step();
    wrmem_end = 1'b1;
    step();
    wrmem_end = 1'b0;
    chk1("wrmem_cmd_done", cmd_done, 1'b1);
    chk1("wrmem_cmd_err", cmd_err, 1'b0);
    step();
    chk1("wrmem_req_ready_back", req_ready, 1'b1);

    // rdreg
    request(2'b10, 32'h0000_0000);
    chk1("rdreg_start", rdreg_start, 1'b1);
    chkw("rdreg_casig", 256'(casig), 256'(48'hE000_0000_0000));
    step();
    rdreg_valid = 1'b1;
    rdreg_data  = 16'h8F1F;
    step();
    rdreg_valid = 1'b0;
    chk1("rdreg_rsp_valid", rsp_valid, 1'b1);
    chkw("rdreg_rsp_data", 256'(rsp_data), 256'(32'h0000_8F1F));
    chk1("rdreg_rsp_last", rsp_last, 1'b1);
    rdreg_end = 1'b1;
    step();
    rdreg_end = 1'b0;
    chk1("rdreg_cmd_done", cmd_done, 1'b1);
    chk1("rdreg_cmd_err", cmd_err, 1'b0);
    step();

    // Timeout: 16 WAIT cycles then DONE with error
    request(2'b00, 32'h0000_0000);
    repeat (16) step();
    chk1("tmo_not_yet", cmd_done, 1'b0);
    step();
    chk1("tmo_cmd_done", cmd_done, 1'b1);
    chk1("tmo_cmd_err", cmd_err, 1'b1);
    step();
    chk1("tmo_req_ready", req_ready, 1'b1);

    // Short rdmem burst ends in error
    request(2'b00, 32'h0000_0040);
    step();
    rdmem_wordvalid = 1'b1;
    rdmem_data = 32'hDEAD_BEEF;
    step();
    rdmem_wordvalid = 1'b0;
    rdmem_end = 1'b1;
    step();
    rdmem_end = 1'b0;
    chk1("short_cmd_done", cmd_done, 1'b1);
    chk1("short_cmd_err", cmd_err, 1'b1);
    step();

    // Illegal op
    request(2'b11, 32'h0000_0000);
    chk1("ill_cmd_done", cmd_done, 1'b1);
    chk1("ill_cmd_err", cmd_err, 1'b1);
    chk1("ill_no_start", rdmem_start | wrmem_start | rdreg_start, 1'b0);
    step();
    chk1("ill_req_ready", req_ready, 1'b1);

    // Reset mid-LOAD after 3 beats
    request(2'b01, 32'h0000_0020);
    chkw("rst2_casig", 256'(casig), 256'(48'h2000_0004_0000));
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hC0 + i;
      step();
    end
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("rst2_wr_ready", wr_ready, 1'b0);
    chkw("rst2_casig_clr", 256'(casig), 256'(0));
    chkw("rst2_dbuf_clr", databuffer, 256'(0));
    chk1("rst2_req_ready", req_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    chk1("rst2_idle", req_ready, 1'b1);
    chk1("rst2_no_start", wrmem_start, 1'b0);
    request(2'b01, 32'h0000_0020);
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hB0 + i;
      step();
    end
    chk1("rst2_need8_start", wrmem_start, 1'b0);
    chk1("rst2_need8_ready", wr_ready, 1'b1);
    wr_data = 32'hB7;
    step();
    wr_valid = 1'b0;
    chk1("rst2_start", wrmem_start, 1'b1);
    chkw("rst2_dbuf_top", 256'(databuffer[255:224]), 256'(32'hB0));
    chkw("rst2_dbuf_bot", 256'(databuffer[31:0]), 256'(32'hB7));
    step();
    wrmem_end = 1'b1;
    step();
    wrmem_end = 1'b0;
    chk1("rst2_cmd_done", cmd_done, 1'b1);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hram_cmd_ctrl.md
# hram_cmd_ctrl

Command front-end for the HyperRAM controller. It accepts user read and write requests, builds the 48-bit HyperBus command-address word and packs write data into the 256-bit burst buffer. It then launches exactly one of the read-memory, write-memory or read-register sequencers and returns read data with a per-command completion status. It sits directly upstream of those sequencers and drives their `stm_start`, `casig`, `databuffer` and `valid` inputs.

## Interface
- `TIMEOUT`, default 256: cycles allowed in WAIT before the command is aborted.
- `clk` in 1: single clock. All outputs are registered to it.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: command request.
- `req_ready` out 1: command accept.
- `req_op` in 2: operation select.
  - 00: rdmem.
  - 01: wrmem.
  - 10: rdreg.
  - 11: illegal.
- `req_addr` in 32: 16-bit-word address.
- `wr_data` in 32: write beat.
- `wr_valid` in 1: write beat handshake, input side.
- `wr_ready` out 1: write beat handshake, output side.
- `rsp_data` out 32: read data.
- `rsp_valid` out 1: read data strobe. There is no backpressure; the consumer must take every strobe.
- `rsp_last` out 1: marks the final read beat.
- `cmd_done` out 1: one-cycle command completion pulse.
- `cmd_err` out 1: error flag, valid only with `cmd_done`.
- `casig` out 48: command-address word to the sequencers.
- `databuffer` out 256: write burst buffer.
- `databuffer_valid` out 1: write burst buffer valid.
- `rdmem_start`, `wrmem_start`, `rdreg_start` out 1 each: sequencer launch.
- `rdmem_end`, `wrmem_end`, `rdreg_end` in 1 each: sequencer completion.
- `rdmem_data` in 32: read-memory word.
- `rdmem_wordvalid` in 1: read-memory word strobe.
- `rdreg_data` in 16: read-register data.
- `rdreg_valid` in 1: read-register data strobe.

## Operation
- FSM states: IDLE, LOAD, ISSUE, WAIT, DONE.
- **IDLE**
  - `req_ready`=1.
  - On handshake, latch op and address, and register `casig`.
  - Next state is LOAD for wrmem, ISSUE for rdmem or rdreg, and DONE with err for op 11.
- **casig construction**
  - [47] = 1 for reads.
  - [46] = 1 for rdreg.
  - [45] = 1 (linear burst).
  - [44:16] = addr[31:3].
  - [15:3] = 0.
  - [2:0] = addr[2:0].
  - `casig` is held constant from acceptance until the next acceptance.
- **LOAD**
  - `wr_ready`=1. Accept 8 beats, MSB-first: beat k goes to `databuffer[255-32k -: 32]`.
  - After the 8th beat, `databuffer_valid`=1 and the FSM moves to ISSUE.
  - `databuffer_valid` stays 1 through the ISSUE cycle and clears on entry to WAIT.
- **ISSUE**
  - The selected `*_start` is 1 for exactly this one cycle. The other starts stay 0.
  - Next state is WAIT.
- **WAIT**
  - rdmem: each `rdmem_wordvalid` produces `rsp_valid`=1 with `rsp_data`=`rdmem_data`, one cycle later. The 8th word also sets `rsp_last`.
  - rdreg: `rdreg_valid` produces `rsp_data`={16'h0, `rdreg_data`} with `rsp_valid` and `rsp_last`.
  - The matching `*_end` moves the FSM to DONE. The `*_end` of non-selected sequencers is ignored.
  - A cycle counter runs from 0. Reaching TIMEOUT-1 without the matching end moves the FSM to DONE with err.
- **DONE**
  - `cmd_done`=1 for one cycle, with `cmd_err` set for timeout, op 11, or rdmem ending with ≠8 words.
  - Next state is IDLE.
- **Simultaneous events**: a strobe arriving in the same cycle as `*_end` is forwarded, and the word counter includes it.

## Timing
- **Reset values** (`rst_n` low, asynchronous):
  - State IDLE.
  - All outputs 0, except `req_ready`=1 once `rst_n` deasserts.
  - `casig`=0, `databuffer`=0, counters 0.
- **Reset mid-command**: everything aborts immediately. No `cmd_done` is produced and no start is re-issued.
- **Latency, reads**: req handshake at cycle 0 → `*_start` at cycle 1.
- **Latency, writes**: last write beat at cycle n → `wrmem_start` at cycle n+1.
- **Completion**: `*_end` at cycle m → `cmd_done` at cycle m+1 → `req_ready` at cycle m+2.
- **Read data**: `rsp_valid` lags its strobe by exactly 1 cycle.
- **Handshake rules**:
  - `wr_ready` is 0 outside LOAD; beats offered there are not consumed.
  - `req_ready` is 0 outside IDLE.
- **Timeout**: the counter saturates. It is 8 bits at default and sized by $clog2(TIMEOUT).

## Test plan
- **rdmem**: req op 00, addr 0x0000_1234.
  - Expect `casig`=0xA000_0246_0004 and a `rdmem_start` pulse at cycle 1.
  - Drive 8 words 0x11111111..0x88888888 → 8 `rsp_valid` with `rsp_last` on the 8th, then `cmd_done`=1 with `cmd_err`=0.
- **wrmem**: op 01, addr 0x10, beats 0xA0..0xA7.
  - Expect `casig`=0x2000_0002_0000, `databuffer[255:224]`=0xA0, `[31:0]`=0xA7, `databuffer_valid` high during the start cycle, and `wrmem_start` the cycle after beat 8.
  - Expect `cmd_done` the cycle after `wrmem_end`.
- **rdreg**: op 10, addr 0.
  - Expect `casig`=0xE000_0000_0000.
  - `rdreg_data`=0x8F1F → `rsp_data`=0x0000_8F1F with `rsp_last`=1, then `cmd_done`.
- **Timeout**: TIMEOUT=16, rdmem with `rdmem_end` never driven → `cmd_done` with `cmd_err`=1 after exactly 16 WAIT cycles, and `req_ready` back high.
- **Illegal op and stray ends**: op 11 → no start pulse, `cmd_done` with `cmd_err`=1 at cycle 1. Also pulse `wrmem_end` during an rdmem WAIT → ignored.
- **Reset mid-command**: assert `rst_n` low during LOAD after 3 beats → all outputs 0 asynchronously, and the next wrmem requires 8 fresh beats.
